// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   start     in   launch request, sampled only in IDLE
//   op        in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      in   operands (rs / dividend, rt / divisor)
//   hi_we     in   MTHI strobe (IDLE only)
//   lo_we     in   MTLO strobe (IDLE only)
//   wdata     in   MTHI/MTLO data
//   hi, lo    out  architectural HI/LO registers
//   busy      out  state is not IDLE
//   done      out  one-cycle completion pulse
//   div_zero  out  divide-by-zero flag, valid while done
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [2*WIDTH-1:0] acc;       // mul: {partial upper, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   operand;   // multiplicand or divisor magnitude
  logic [CW-1:0]      count;
  logic               is_div;
  logic               lo_neg;    // product sign (mul) / quotient sign (div)
  logic               hi_neg;    // product sign (mul) / remainder sign (div)
  logic               dz;

  // Launch-time decode
  logic             op_signed, op_div, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_signed = ~op[0];
  assign op_div    = op[1];
  assign b_zero    = (b == '0);
  assign a_mag     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // One shift-add multiply step: the carry out of the add becomes the new MSB
  // once the whole product shifts right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring divide step: trial is the remainder shifted left with the
  // next dividend bit brought in from the quotient half.
  logic [WIDTH:0]     div_trial, div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign div_trial = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, operand};
  assign div_next  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  // Sign fix-up of the finished magnitudes
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  assign prod_fixed = lo_neg ? (~acc + 1'b1) : acc;
  assign quo_fixed  = lo_neg ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fixed  = hi_neg ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (op_div && b_zero) ? DONE : RUN;
      RUN:  if (count == CW'(1)) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    div_zero = (state == DONE) && dz;
  end

  // Datapath and HI/LO
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      operand <= '0;
      count   <= '0;
      is_div  <= 1'b0;
      lo_neg  <= 1'b0;
      hi_neg  <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div  <= op_div;
            count   <= CW'(WIDTH);
            dz      <= op_div && b_zero;
            lo_neg  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            if (op_div) begin
              acc     <= {{WIDTH{1'b0}}, a_mag};
              operand <= b_mag;
              hi_neg  <= op_signed && a[WIDTH-1];
            end else begin
              acc     <= {{WIDTH{1'b0}}, b_mag};
              operand <= a_mag;
              hi_neg  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            end
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count - 1'b1;
        end
        FIX: begin
          if (is_div) begin
            lo <= quo_fixed;
            hi <= rem_fixed;
          end else begin
            lo <= prod_fixed[WIDTH-1:0];
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed-vector self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int vectors     = 0;
  int miscompares = 0;

  // Results captured by run_op
  int          busy_cycles, done_at, done_count;
  logic [31:0] got_hi, got_lo;
  logic        got_dz;
  logic        poke_start = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Launch at the next rising edge, then follow the op until busy drops.
  // done_at is the index (0 = cycle right after the launch edge) of the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int guard;
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;   // operands must have been latched
    busy_cycles = 0; done_at = -1; done_count = 0; guard = 0;
    got_hi = '0; got_lo = '0; got_dz = 1'b0;
    while (busy && guard < 100) begin
      if (done) begin
        done_count++;
        done_at = busy_cycles;
        got_hi = hi; got_lo = lo; got_dz = div_zero;
      end
      start = (poke_start && busy_cycles == 10);
      busy_cycles++;
      guard++;
      @(negedge clock);
    end
    start = 1'b0;
    check("busy_timeout", 32'(guard >= 100), 32'd0);
  endtask

  initial begin
    int seen;

    // Reset state
    #12;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_flags", {29'd0, busy, done, div_zero}, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // MULT -2 * 3
    run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_hi", got_hi, 32'hFFFF_FFFF);
    check("mult_lo", got_lo, 32'hFFFF_FFFA);
    check("mult_dz", {31'd0, got_dz}, 32'h0);
    check("mult_done_at", done_at, 32'd33);

    // MULTU max * max, busy length
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", got_hi, 32'hFFFF_FFFE);
    check("multu_lo", got_lo, 32'h0000_0001);
    check("multu_busy_len", busy_cycles, 32'd34);
    check("multu_done_cnt", done_count, 32'd1);

    // DIV / DIVU -7 by 2
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_lo", got_lo, 32'hFFFF_FFFD);
    check("div_hi", got_hi, 32'hFFFF_FFFF);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    check("divu_lo", got_lo, 32'h7FFF_FFFC);
    check("divu_hi", got_hi, 32'h0000_0001);
    check("divu_dz", {31'd0, got_dz}, 32'h0);

    // MTHI / MTLO, then divide by zero keeps them
    @(negedge clock);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
    @(negedge clock);
    lo_we = 1'b0;
    check("mthi", hi, 32'h1234_5678);
    check("mtlo", lo, 32'h9ABC_DEF0);
    run_op(2'b10, 32'h0000_0005, 32'h0);
    check("dz_flag", {31'd0, got_dz}, 32'h1);
    check("dz_done_at", done_at, 32'd0);
    check("dz_busy_len", busy_cycles, 32'd1);
    check("dz_hi_kept", got_hi, 32'h1234_5678);
    check("dz_lo_kept", got_lo, 32'h9ABC_DEF0);

    // Overflow case with a stray start mid-operation
    poke_start = 1'b1;
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    poke_start = 1'b0;
    check("ovf_lo", got_lo, 32'h8000_0000);
    check("ovf_hi", got_hi, 32'h0000_0000);
    check("ovf_dz", {31'd0, got_dz}, 32'h0);
    check("ovf_done_cnt", done_count, 32'd1);
    check("ovf_busy_len", busy_cycles, 32'd34);

    // Reset in the middle of a MULT
    @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'h0000_0007; b = 32'h0000_0009;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'h0);
    check("mid_rst_done", {31'd0, done}, 32'h0);
    check("mid_rst_hi", hi, 32'h0);
    check("mid_rst_lo", lo, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    check("no_late_done", seen, 32'd0);
    run_op(2'b01, 32'd3, 32'd4);
    check("after_rst_lo", got_lo, 32'd12);
    check("after_rst_hi", got_hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
